// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
//  Module      : free_list
//  Description : Physical-register free list. Circular FIFO of free PRF
//                indices: rename pops one index per allocating uop, commit
//                pushes back the stale mapping. A retired head pointer lets
//                a backend flush restore the speculative head in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module free_list #(
    parameter int PRF_DEPTH = 64,
    parameter int ARF_DEPTH = 32,
    parameter int FL_DEPTH  = PRF_DEPTH - ARF_DEPTH,
    parameter int PRF_IDX   = $clog2(PRF_DEPTH),
    parameter int PTR_W     = $clog2(FL_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,               // synchronous, active-low
    input  logic               fl_valid,
    output logic               fl_ready,
    output logic [PRF_IDX-1:0] free_idx,
    input  logic               rob_free_valid,
    input  logic [PRF_IDX-1:0] rob_free_idx,
    input  logic               rob_commit_alloc,
    input  logic               flush,
    output logic [PTR_W-1:0]   occupancy
);

    // Tail starts one full lap ahead of head: every entry is free after reset.
    localparam logic [PTR_W-1:0] c_TAIL_RESET = PTR_W'(FL_DEPTH);

    logic [PRF_IDX-1:0] r_mem [FL_DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_ret_head;
    logic [PTR_W-1:0]   r_tail;

    logic               w_pop;
    logic [PTR_W-1:0]   w_ret_head_nxt;

    // Outputs depend on registered state only, so fl_ready never looks at fl_valid.
    assign fl_ready  = (r_head != r_tail);
    assign free_idx  = r_mem[r_head[PTR_W-2:0]];
    assign occupancy = r_tail - r_head;

    // A pop issued during a flush is dropped; the flush owns the head update.
    assign w_pop          = fl_valid && fl_ready && !flush;
    assign w_ret_head_nxt = r_ret_head + PTR_W'(rob_commit_alloc);

    // Entry storage: reset loads the initially free indices, commit writes at tail.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                r_mem[i] <= PRF_IDX'(ARF_DEPTH + i);
            end
        end else if (rob_free_valid) begin
            r_mem[r_tail[PTR_W-2:0]] <= rob_free_idx;
        end
    end

    // Pointer update: speculative head, retired head and tail.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head     <= '0;
            r_ret_head <= '0;
            r_tail     <= c_TAIL_RESET;
        end else begin
            r_ret_head <= w_ret_head_nxt;
            r_tail     <= r_tail + PTR_W'(rob_free_valid);
            if (flush) begin
                r_head <= w_ret_head_nxt;
            end else begin
                r_head <= r_head + PTR_W'(w_pop);
            end
        end
    end

`ifndef SYNTHESIS
    // Full is measured against the retired head: in-flight entries still own their slots.
    logic [PTR_W-1:0] w_committed_cnt;
    assign w_committed_cnt = r_tail - r_ret_head;

    a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst)
        !(rob_free_valid && (w_committed_cnt == c_TAIL_RESET)))
        else $error("free_list: push into full list");

    a_ret_head_le_head : assert property (@(posedge clk) disable iff (!rst)
        !(rob_commit_alloc && (r_ret_head == r_head) && !w_pop))
        else $error("free_list: retired head passing speculative head");
`endif

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
//  Module      : tb_free_list
//  Description : Self-checking bench for free_list. A queue-based reference
//                model tracks the committed free entries and how many of
//                them have been speculatively handed out.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst;
    logic       fl_valid;
    logic       fl_ready;
    logic [5:0] free_idx;
    logic       rob_free_valid;
    logic [5:0] rob_free_idx;
    logic       rob_commit_alloc;
    logic       flush;
    logic [5:0] occupancy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: q holds every entry between the retired head and the
    // tail; the first n_pop of them are handed out but not yet retired.
    logic [5:0] q[$];
    int         n_pop;

    free_list dut (
        .clk              (clk),
        .rst              (rst),
        .fl_valid         (fl_valid),
        .fl_ready         (fl_ready),
        .free_idx         (free_idx),
        .rob_free_valid   (rob_free_valid),
        .rob_free_idx     (rob_free_idx),
        .rob_commit_alloc (rob_commit_alloc),
        .flush            (flush),
        .occupancy        (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) q.push_back(6'(32 + i));
        n_pop = 0;
    endtask

    task automatic check_model(input string tag);
        logic exp_ready;
        exp_ready = (n_pop < q.size());
        chk({tag, ".ready"}, 32'(fl_ready), 32'(exp_ready));
        chk({tag, ".occ"}, 32'(occupancy), 32'(q.size() - n_pop));
        if (exp_ready) chk({tag, ".idx"}, 32'(free_idx), 32'(q[n_pop]));
    endtask

    task automatic drive(input logic rs, input logic v, input logic fv,
                         input logic [5:0] fi, input logic ca, input logic fl);
        rst              = rs;
        fl_valid         = v;
        rob_free_valid   = fv;
        rob_free_idx     = fi;
        rob_commit_alloc = ca;
        flush            = fl;
    endtask

    // One clock: apply inputs, advance the model by the same rules, compare.
    task automatic step(input logic rs, input logic v, input logic fv,
                        input logic [5:0] fi, input logic ca, input logic fl,
                        input string tag);
        logic pop;
        drive(rs, v, fv, fi, ca, fl);
        @(posedge clk);
        if (!rs) begin
            model_reset();
        end else begin
            pop = v && (n_pop < q.size()) && !fl;
            if (pop) n_pop++;
            if (ca) begin
                void'(q.pop_front());
                n_pop--;
            end
            if (fv) q.push_back(fi);
            if (fl) n_pop = 0;
        end
        #1;
        check_model(tag);
    endtask

    initial begin
        logic       v, fv, ca, fl;
        logic [5:0] fi;

        drive(1'b0, 0, 0, 6'd0, 0, 0);
        step(1'b0, 0, 0, 6'd0, 0, 0, "rst");
        step(1'b1, 0, 0, 6'd0, 0, 0, "idle");
        chk("reset.ready", 32'(fl_ready), 32'd1);
        chk("reset.idx", 32'(free_idx), 32'd32);
        chk("reset.occ", 32'(occupancy), 32'd32);

        // Drain all 32 reset entries in order.
        for (int i = 0; i < 32; i++) begin
            chk("drain.idx", 32'(free_idx), 32'(32 + i));
            step(1'b1, 1, 0, 6'd0, 0, 0, "drain");
        end
        chk("empty.ready", 32'(fl_ready), 32'd0);
        chk("empty.occ", 32'(occupancy), 32'd0);
        step(1'b1, 1, 0, 6'd0, 0, 0, "pop_empty");
        chk("pop_empty.occ", 32'(occupancy), 32'd0);

        // Retire four allocations so pushes are legal.
        for (int i = 0; i < 4; i++) step(1'b1, 0, 0, 6'd0, 1, 0, "retire");

        // Push into empty list: not visible until the next cycle.
        drive(1'b1, 0, 1, 6'd5, 0, 0);
        #1;
        chk("push5.same_ready", 32'(fl_ready), 32'd0);
        step(1'b1, 0, 1, 6'd5, 0, 0, "push5");
        chk("push5.ready", 32'(fl_ready), 32'd1);
        chk("push5.idx", 32'(free_idx), 32'd5);

        // Simultaneous pop and push at occupancy 1.
        chk("poppush.old_idx", 32'(free_idx), 32'd5);
        step(1'b1, 1, 1, 6'd9, 0, 0, "poppush");
        chk("poppush.occ", 32'(occupancy), 32'd1);
        chk("poppush.idx", 32'(free_idx), 32'd9);

        // Flush restores head to the retired head; concurrent pop is dropped.
        step(1'b0, 0, 0, 6'd0, 0, 0, "rst2");
        for (int i = 0; i < 3; i++) step(1'b1, 1, 0, 6'd0, 0, 0, "fpop");
        step(1'b1, 0, 0, 6'd0, 1, 0, "fcommit");
        step(1'b1, 1, 0, 6'd0, 0, 1, "flush");
        chk("flush.idx", 32'(free_idx), 32'd33);
        chk("flush.occ", 32'(occupancy), 32'd31);

        // Randomized traffic within the legal protocol.
        for (int c = 0; c < 600; c++) begin
            v  = ($urandom % 4) != 0;
            fl = ($urandom % 20) == 0;
            ca = (n_pop > 0) && (($urandom % 3) == 0);
            fv = (q.size() < 32) && (($urandom % 2) == 0);
            fi = 6'($urandom);
            step(1'b1, v, fv, fi, ca, fl, "rand");
        end

        // Three full fill/drain laps to walk the pointers through wrap.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 40 && n_pop < q.size(); k++)
                step(1'b1, 1, 0, 6'd0, 0, 0, "lap_pop");
            for (int k = 0; k < 40 && n_pop > 0; k++)
                step(1'b1, 0, 0, 6'd0, 1, 0, "lap_ret");
            for (int k = 0; k < 40 && q.size() < 32; k++)
                step(1'b1, 0, 1, 6'($urandom), 0, 0, "lap_push");
        end
        chk("lap.occ", 32'(occupancy), 32'd32);

        // Reset in the middle of traffic overrides every input.
        for (int k = 0; k < 5; k++) step(1'b1, 1, 0, 6'd0, 0, 0, "pre_rst");
        step(1'b1, 1, 0, 6'd0, 1, 0, "pre_rst_ret");
        step(1'b0, 1, 1, 6'd17, 1, 1, "mid_rst");
        chk("mid_rst.ready", 32'(fl_ready), 32'd1);
        chk("mid_rst.idx", 32'(free_idx), 32'd32);
        chk("mid_rst.occ", 32'(occupancy), 32'd32);
        step(1'b1, 1, 0, 6'd0, 0, 0, "post_rst");
        chk("post_rst.idx", 32'(free_idx), 32'd33);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
